// File: rtl/mem_array_clr.sv
// ---------------------------------------------------------------------------
// mem_array_clr
//
// Single-clock word memory with byte-lane write enables, a registered read
// port with valid flag, out-of-range detection and a sequenced clear engine
// that zeroes one word per cycle while busy is high.
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   DEPTH   number of words (>= 2, any value)
//   ADDR_W  derived address width
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset (clears array and outputs)
//   clear_req  start a clear sweep (sampled in IDLE only)
//   busy       high while the clear sweep runs
//   wr_en      write strobe
//   wr_addr    write word address
//   wr_be      byte-lane write enables
//   wr_data    write data
//   rd_en      read strobe
//   rd_addr    read word address
//   rd_data    registered read data (holds when no read is accepted)
//   rd_valid   rd_data valid this cycle
//   oob_err    one-cycle pulse, access to an address >= DEPTH last cycle
// ---------------------------------------------------------------------------
module mem_array_clr #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  oob_err
);

   localparam int                LANES    = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_in_range, rd_in_range;
   logic                wr_acc, rd_acc, wr_oob, rd_oob;
   logic [DATA_W-1:0]   rd_word_p0;

   logic [DATA_W-1:0]   rd_data_p1;
   logic                vld_p1;
   logic                oob_p1;

   // Replace only the enabled byte lanes of old_word with new_word.
   function automatic logic [DATA_W-1:0] merge_lanes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [LANES-1:0]  be
   );
      logic [DATA_W-1:0] r;
      r = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
      end
      return r;
   endfunction

   // Clear sequencer: next state, pointer and busy flag
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            busy  = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Access qualification: everything is ignored during the sweep
   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
      rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
      wr_acc      = wr_en & ~busy & wr_in_range;
      wr_oob      = wr_en & ~busy & ~wr_in_range;
      rd_acc      = rd_en & ~busy;
      rd_oob      = rd_en & ~busy & ~rd_in_range;
   end

   // Stage p0: read word with same-cycle write forwarded lane by lane;
   // out-of-range reads return zero.
   always_comb begin
      rd_word_p0 = '0;
      if (rd_in_range) begin
         rd_word_p0 = mem[rd_addr];
         if (wr_acc && (wr_addr == rd_addr)) begin
            rd_word_p0 = merge_lanes(rd_word_p0, wr_data, wr_be);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (busy) begin
         mem[ptr_q] <= '0;
      end else if (wr_acc) begin
         mem[wr_addr] <= merge_lanes(mem[wr_addr], wr_data, wr_be);
      end
   end

   // Stage p1: registered read port, error flag and sequencer state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         rd_data_p1 <= '0;
         vld_p1     <= 1'b0;
         oob_p1     <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         vld_p1  <= rd_acc;
         oob_p1  <= wr_oob | rd_oob;
         if (rd_acc) rd_data_p1 <= rd_word_p0;
      end
   end

   assign rd_data  = rd_data_p1;
   assign rd_valid = vld_p1;
   assign oob_err  = oob_p1;

endmodule

// File: tb/tb_mem_array_clr.sv
// ---------------------------------------------------------------------------
// tb_mem_array_clr
//
// Scoreboard bench for mem_array_clr. Instance a: DATA_W=16, DEPTH=8.
// Instance b: DATA_W=16, DEPTH=6 (exercises out-of-range addresses).
// Expected read words are queued when a read is driven and compared when
// rd_valid appears.
// ---------------------------------------------------------------------------
module tb_mem_array_clr;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance a signals
   logic        a_clear_req = 0, a_busy, a_wr_en = 0, a_rd_en = 0;
   logic [2:0]  a_wr_addr = 0, a_rd_addr = 0;
   logic [1:0]  a_wr_be = 0;
   logic [15:0] a_wr_data = 0, a_rd_data;
   logic        a_rd_valid, a_oob_err;

   // instance b signals
   logic        b_clear_req = 0, b_busy, b_wr_en = 0, b_rd_en = 0;
   logic [2:0]  b_wr_addr = 0, b_rd_addr = 0;
   logic [1:0]  b_wr_be = 0;
   logic [15:0] b_wr_data = 0, b_rd_data;
   logic        b_rd_valid, b_oob_err;

   // reference models and scoreboards
   logic [15:0] a_mem [8];
   logic [15:0] b_mem [6];
   logic [15:0] a_q [$];
   logic [15:0] b_q [$];
   logic        a_busy_exp = 0;
   logic        b_oob_exp  = 0;
   int          a_busy_cnt = 0;

   mem_array_clr #(.DATA_W(16), .DEPTH(8)) dut_a (
      .clk(clk), .reset(reset), .clear_req(a_clear_req), .busy(a_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
      .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .rd_valid(a_rd_valid), .oob_err(a_oob_err)
   );

   mem_array_clr #(.DATA_W(16), .DEPTH(6)) dut_b (
      .clk(clk), .reset(reset), .clear_req(b_clear_req), .busy(b_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
      .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .oob_err(b_oob_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      b_oob_exp = 1'b0;
   endtask

   task automatic a_op(input logic w, input logic [2:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input logic r, input logic [2:0] ra);
      a_wr_en = w; a_wr_addr = wa; a_wr_be = be; a_wr_data = wd;
      a_rd_en = r; a_rd_addr = ra;
      // write-first: update the model, then take the read from it
      if (w) for (int i = 0; i < 2; i++) if (be[i]) a_mem[wa][8*i +: 8] = wd[8*i +: 8];
      if (r) a_q.push_back(a_mem[ra]);
      tick();
      a_wr_en = 0; a_rd_en = 0;
   endtask

   task automatic b_op(input logic w, input logic [2:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input logic r, input logic [2:0] ra);
      logic oob;
      b_wr_en = w; b_wr_addr = wa; b_wr_be = be; b_wr_data = wd;
      b_rd_en = r; b_rd_addr = ra;
      if (w && wa < 6) for (int i = 0; i < 2; i++) if (be[i]) b_mem[wa][8*i +: 8] = wd[8*i +: 8];
      if (r) b_q.push_back((ra < 6) ? b_mem[ra] : 16'h0000);
      oob = (w && wa >= 6) || (r && ra >= 6);
      tick();
      b_oob_exp = oob;
      b_wr_en = 0; b_rd_en = 0;
   endtask

   // Run a full clear on instance a; pokes a read and a write mid-sweep.
   task automatic a_clear_run();
      a_clear_req = 1;
      tick();
      a_clear_req = 0;
      a_busy_exp  = 1;
      a_busy_cnt  = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            a_rd_en = 1; a_rd_addr = 3'd2;
            a_wr_en = 1; a_wr_addr = 3'd0; a_wr_be = 2'b11; a_wr_data = 16'hFFFF;
         end
         tick();
         a_rd_en = 0; a_wr_en = 0;
         if (i == 7) a_busy_exp = 0;
      end
      chk("a_busy_len", a_busy_cnt, 8);
      for (int k = 0; k < 8; k++) a_mem[k] = 16'h0000;
   endtask

   // Output monitor on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         chk("a_busy", a_busy, a_busy_exp);
         chk("a_oob", a_oob_err, 0);
         chk("b_busy", b_busy, 0);
         chk("b_oob", b_oob_err, b_oob_exp);
         if (a_busy) a_busy_cnt++;
         if (a_rd_valid) begin
            if (a_q.size() == 0) chk("a_unexp_vld", a_rd_valid, 0);
            else chk("a_rd", a_rd_data, a_q.pop_front());
         end
         if (b_rd_valid) begin
            if (b_q.size() == 0) chk("b_unexp_vld", b_rd_valid, 0);
            else chk("b_rd", b_rd_data, b_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 8; k++) a_mem[k] = 16'h0000;
      for (int k = 0; k < 6; k++) b_mem[k] = 16'h0000;

      // reset state
      #12;
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_vld", a_rd_valid, 0);
      chk("rst_a_data", a_rd_data, 0);
      chk("rst_a_oob", a_oob_err, 0);
      chk("rst_b_vld", b_rd_valid, 0);
      chk("rst_b_oob", b_oob_err, 0);
      @(posedge clk); #3 reset = 0;
      tick();

      // read all addresses after reset
      for (int i = 0; i < 8; i++) a_op(0, 0, 0, 0, 1, 3'(i));
      tick();

      // byte-lane writes and write-first forwarding
      a_op(1, 3'd3, 2'b11, 16'hBEEF, 0, 0);
      a_op(1, 3'd3, 2'b10, 16'h1234, 0, 0);
      a_op(0, 0, 0, 0, 1, 3'd3);
      tick();
      chk("a_hold", a_rd_data, 16'h12EF);
      a_op(1, 3'd5, 2'b11, 16'hA5A5, 1, 3'd5);
      a_op(1, 3'd5, 2'b01, 16'h9933, 1, 3'd5);
      a_op(1, 3'd6, 2'b00, 16'h7777, 1, 3'd6);
      a_op(0, 0, 0, 0, 1, 3'd5);

      // fill, then clear with ignored accesses during the sweep
      for (int i = 0; i < 8; i++) a_op(1, 3'(i), 2'b11, 16'h1111 * 16'(i + 1), 0, 0);
      a_op(0, 0, 0, 0, 1, 3'd7);
      a_clear_run();
      for (int i = 0; i < 8; i++) a_op(0, 0, 0, 0, 1, 3'(i));

      // out-of-range on the DEPTH=6 instance
      for (int i = 0; i < 6; i++) b_op(1, 3'(i), 2'b11, 16'hC000 + 16'(i), 0, 0);
      b_op(1, 3'd7, 2'b11, 16'hDEAD, 0, 0);
      tick();
      for (int i = 0; i < 6; i++) b_op(0, 0, 0, 0, 1, 3'(i));
      b_op(0, 0, 0, 0, 1, 3'd6);
      tick();
      b_op(1, 3'd6, 2'b11, 16'h5555, 1, 3'd2);
      tick();

      // asynchronous reset in cycle 4 of a clear
      for (int i = 0; i < 8; i++) a_op(1, 3'(i), 2'b11, 16'h0F0F ^ 16'(i), 0, 0);
      a_clear_req = 1;
      tick();
      a_clear_req = 0;
      a_busy_exp  = 1;
      tick(); tick(); tick();
      #2;
      reset = 1;
      a_busy_exp = 0;
      #1;
      chk("arst_busy", a_busy, 0);
      chk("arst_vld", a_rd_valid, 0);
      chk("arst_data", a_rd_data, 0);
      for (int k = 0; k < 8; k++) a_mem[k] = 16'h0000;
      for (int k = 0; k < 6; k++) b_mem[k] = 16'h0000;
      @(posedge clk); #3 reset = 0;
      tick();
      for (int i = 0; i < 8; i++) a_op(0, 0, 0, 0, 1, 3'(i));
      for (int i = 0; i < 6; i++) b_op(0, 0, 0, 0, 1, 3'(i));
      for (int i = 0; i < 8; i++) a_op(1, 3'(i), 2'b11, 16'h8001 + 16'(i), 0, 0);
      a_clear_run();
      for (int i = 0; i < 8; i++) a_op(0, 0, 0, 0, 1, 3'(i));
      tick(); tick();

      chk("a_q_empty", a_q.size(), 0);
      chk("b_q_empty", b_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
